// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for Johnson-code handling on the receive side.
//   lock_state_t     : lock FSM states (HUNT, LOCKED, SUSPECT)
//   johnson_idx_w()  : bit width of an index into a 2N-long Johnson sequence
//   johnson_legal()  : 1 when a code has at most one adjacent-bit transition
//   johnson_index()  : sequence position of a legal code
// The code functions take a JOHNSON_MAX_N-wide vector plus the real width n,
// so the same functions serve any instance width (counter-side checks too).
// -----------------------------------------------------------------------------
package johnson_pkg;

    localparam int JOHNSON_MAX_N = 32;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKED  = 2'd1,
        SUSPECT = 2'd2
    } lock_state_t;

    function automatic int johnson_idx_w(input int n);
        return $clog2(2 * n);
    endfunction

    // A Johnson code is a single run of ones against a run of zeros, so a
    // legal code never has more than one place where neighbouring bits differ.
    function automatic logic johnson_legal(input logic [JOHNSON_MAX_N-1:0] code,
                                           input int n);
        int diffs;
        diffs = 0;
        for (int i = 0; i < JOHNSON_MAX_N - 1; i++) begin
            if ((i < n - 1) && (code[i] != code[i+1])) begin
                diffs++;
            end
        end
        return (diffs <= 1);
    endfunction

    // First half of the sequence fills ones from the MSB down (bit 0 still 0),
    // second half drains them from the MSB (bit 0 still 1).
    function automatic int johnson_index(input logic [JOHNSON_MAX_N-1:0] code,
                                         input int n);
        int p;
        p = 0;
        for (int i = 0; i < JOHNSON_MAX_N; i++) begin
            if ((i < n) && code[i]) begin
                p++;
            end
        end
        return code[0] ? (2 * n - p) : p;
    endfunction

endpackage

// File: rtl/johnson_decoder_code_decode.sv
// -----------------------------------------------------------------------------
// johnson_code_decode
// Purely combinational decode of one Johnson code.
//   code_in [N-1:0]   : code to decode
//   legal             : code is a member of the 2N-long Johnson sequence
//   idx   [IDX_W-1:0] : sequence position (meaningful only when legal=1)
//   onehot[2N-1:0]    : onehot[idx] set when legal, all zero otherwise
// -----------------------------------------------------------------------------
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = johnson_idx_w(N)
) (
    input  logic [N-1:0]     code_in,
    output logic             legal,
    output logic [IDX_W-1:0] idx,
    output logic [2*N-1:0]   onehot
);

    logic [JOHNSON_MAX_N-1:0] code_ext;

    always_comb begin
        code_ext          = '0;
        code_ext[N-1:0]   = code_in;
    end

    assign legal = johnson_legal(code_ext, N);
    assign idx   = IDX_W'(johnson_index(code_ext, N));

    for (genvar gi = 0; gi < 2 * N; gi++) begin : g_onehot
        assign onehot[gi] = legal && (idx == IDX_W'(gi));
    end

endmodule

// File: rtl/johnson_decoder.sv
// -----------------------------------------------------------------------------
// johnson_decoder
// Samples a Johnson code on en, decodes it and tracks sequence lock.
//   clk, res           : clock; synchronous active-high reset
//   en                 : sample strobe, code_in evaluated only when en=1
//   code_in [N-1:0]    : Johnson code from the counter
//   clr_err            : synchronous clear of err_cnt (beats a same-cycle error)
//   idx  [IDX_W-1:0]   : index of the last legal sample
//   onehot [2N-1:0]    : one-hot of idx when the last sample was legal, else 0
//   code_valid         : last sample was legal
//   locked             : lock FSM in LOCKED or SUSPECT
//   seq_err            : one-cycle pulse on a bad sample while locked/suspect
//   err_cnt [ERR_W-1:0]: saturating count of seq_err pulses
// All outputs are registered and reflect the sample taken on the prior edge.
// -----------------------------------------------------------------------------
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int LOCK_CNT = 3,
    parameter  int ERR_W    = 8,
    localparam int IDX_W    = johnson_idx_w(N)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [N-1:0]     code_in,
    input  logic             clr_err,
    output logic [IDX_W-1:0] idx,
    output logic [2*N-1:0]   onehot,
    output logic             code_valid,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N - 1);

    logic             dec_legal;
    logic [IDX_W-1:0] dec_idx;
    logic [2*N-1:0]   dec_onehot;

    lock_state_t      state_reg, state_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic [IDX_W-1:0] idx_reg;
    logic             have_prev_reg;
    logic [2*N-1:0]   onehot_reg;
    logic             code_valid_reg;
    logic             seq_err_reg, seq_err_next;
    logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

    logic [IDX_W-1:0] succ_idx;
    logic             in_seq;
    logic [RUN_W-1:0] hunt_run;

    johnson_code_decode #(.N(N)) u_decode (
        .code_in (code_in),
        .legal   (dec_legal),
        .idx     (dec_idx),
        .onehot  (dec_onehot)
    );

    // idx_reg only ever loads legal samples, so it doubles as the previous
    // legal index used for the successor check.
    assign succ_idx = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    assign in_seq   = dec_legal && have_prev_reg && (dec_idx == succ_idx);

    always_comb begin
        state_next   = state_reg;
        run_next     = run_reg;
        seq_err_next = 1'b0;
        err_cnt_next = err_cnt_reg;

        // Run length as HUNT would compute it from this sample; also used when
        // SUSPECT falls back to HUNT.
        if (!dec_legal) begin
            hunt_run = '0;
        end else if (in_seq) begin
            hunt_run = run_reg + 1'b1;
        end else begin
            hunt_run = RUN_W'(1);
        end

        if (en) begin
            case (state_reg)
                HUNT: begin
                    run_next = hunt_run;
                    if (hunt_run == RUN_W'(LOCK_CNT)) begin
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!in_seq) begin
                        state_next   = SUSPECT;
                        seq_err_next = 1'b1;
                    end
                end
                SUSPECT: begin
                    if (in_seq) begin
                        state_next = LOCKED;
                    end else begin
                        state_next   = HUNT;
                        seq_err_next = 1'b1;
                        run_next     = hunt_run;
                    end
                end
                default: begin
                    state_next = HUNT;
                    run_next   = '0;
                end
            endcase
        end

        if (clr_err) begin
            err_cnt_next = '0;
        end else if (seq_err_next && (err_cnt_reg != '1)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg      <= HUNT;
            run_reg        <= '0;
            idx_reg        <= '0;
            have_prev_reg  <= 1'b0;
            onehot_reg     <= '0;
            code_valid_reg <= 1'b0;
            seq_err_reg    <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            run_reg     <= run_next;
            seq_err_reg <= seq_err_next;
            err_cnt_reg <= err_cnt_next;
            if (en) begin
                code_valid_reg <= dec_legal;
                onehot_reg     <= dec_onehot;
                if (dec_legal) begin
                    idx_reg       <= dec_idx;
                    have_prev_reg <= 1'b1;
                end
            end
        end
    end

    assign idx        = idx_reg;
    assign onehot     = onehot_reg;
    assign code_valid = code_valid_reg;
    assign locked     = (state_reg != HUNT);
    assign seq_err    = seq_err_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_johnson_decoder.sv
// -----------------------------------------------------------------------------
// tb_johnson_decoder
// Directed and random stimulus for johnson_decoder (N=4, LOCK_CNT=3, ERR_W=2).
// A driver applies one sample per cycle and pushes the reference model's
// expected outputs into a queue; a monitor pops and compares one entry per
// cycle. The model decodes by table lookup into the Johnson sequence.
// -----------------------------------------------------------------------------
module tb_johnson_decoder;

    localparam int N        = 4;
    localparam int LOCK_CNT = 3;
    localparam int ERR_W    = 2;
    localparam int L        = 2 * N;
    localparam int IDX_W    = $clog2(L);
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic             en = 1'b0;
    logic [N-1:0]     code_in = '0;
    logic             clr_err = 1'b0;
    logic [IDX_W-1:0] idx;
    logic [L-1:0]     onehot;
    logic             code_valid;
    logic             locked;
    logic             seq_err;
    logic [ERR_W-1:0] err_cnt;

    always #5 clk = ~clk;

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .res        (res),
        .en         (en),
        .code_in    (code_in),
        .clr_err    (clr_err),
        .idx        (idx),
        .onehot     (onehot),
        .code_valid (code_valid),
        .locked     (locked),
        .seq_err    (seq_err),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        int idx;
        int onehot;
        int valid;
        int locked;
        int seq_err;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   txn   = 0;
    int   seq_tab[L];

    // Reference model state
    int m_state;   // 0 hunting, 1 locked, 2 suspect
    int m_run, m_idx, m_onehot, m_err;
    int m_have, m_valid, m_seq_err;

    function automatic int lookup(input int code);
        for (int k = 0; k < L; k++) begin
            if (seq_tab[k] == code) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input bit e, input int code, input bit clr, input bit rst);
        int  k;
        bit  good;
        exp_t x;
        if (rst) begin
            m_state = 0; m_run = 0; m_idx = 0; m_onehot = 0; m_err = 0;
            m_have = 0; m_valid = 0; m_seq_err = 0;
        end else begin
            k    = lookup(code);
            good = (k >= 0) && (m_have != 0) && (k == (m_idx + 1) % L);
            m_seq_err = 0;
            if (e) begin
                case (m_state)
                    0: begin
                        m_run = (k < 0) ? 0 : (good ? m_run + 1 : 1);
                        if (m_run == LOCK_CNT) m_state = 1;
                    end
                    1: begin
                        if (!good) begin m_state = 2; m_seq_err = 1; end
                    end
                    default: begin
                        if (good) m_state = 1;
                        else begin
                            m_state = 0; m_seq_err = 1;
                            m_run = (k < 0) ? 0 : 1;
                        end
                    end
                endcase
                if (k >= 0) begin
                    m_idx = k; m_have = 1; m_valid = 1; m_onehot = 1 << k;
                end else begin
                    m_valid = 0; m_onehot = 0;
                end
            end
            if (clr) m_err = 0;
            else if (m_seq_err != 0 && m_err < ERR_MAX) m_err++;
        end
        x.idx = m_idx; x.onehot = m_onehot; x.valid = m_valid;
        x.locked = (m_state != 0) ? 1 : 0; x.seq_err = m_seq_err; x.err = m_err;
        exp_q.push_back(x);
    endtask

    task automatic drive(input bit e, input int code, input bit clr, input bit rst);
        @(negedge clk);
        en      = e;
        code_in = code[N-1:0];
        clr_err = clr;
        res     = rst;
        model_step(e, code, clr, rst);
    endtask

    task automatic feed(input int k);
        drive(1'b1, seq_tab[k % L], 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s txn=%0d actual=%0d required=%0d", name, txn, act, req);
        end
    endtask

    // Monitor: one expected entry per cycle, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("[TB] txn %0d idx=%0d onehot=%02h valid=%0b locked=%0b seq_err=%0b err_cnt=%0d",
                         txn, idx, onehot, code_valid, locked, seq_err, err_cnt);
                chk("idx",        int'(idx),        e.idx);
                chk("onehot",     int'(onehot),     e.onehot);
                chk("code_valid", int'(code_valid), e.valid);
                chk("locked",     int'(locked),     e.locked);
                chk("seq_err",    int'(seq_err),    e.seq_err);
                chk("err_cnt",    int'(err_cnt),    e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        int r;
        bit e;
        bit c;
        bit rs;
        int code;

        for (int k = 0; k < L; k++) begin
            seq_tab[k] = (k <= N) ? (((1 << k) - 1) << (N - k)) : ((1 << (L - k)) - 1);
        end

        // Reset
        drive(1'b0, 0, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);

        // Full sequence from 0000 plus wrap back to 0000
        for (int k = 0; k <= L; k++) feed(k);

        // Locked at idx 0: advance to idx 2, inject illegal 0100, recover with 1110
        feed(1); feed(2);
        drive(1'b1, 4'b0100, 1'b0, 1'b0);
        feed(3);

        // Two bad samples: out-of-sequence 1100 then a repeat, then relock
        drive(1'b1, 4'b1100, 1'b0, 1'b0);
        drive(1'b1, 4'b1100, 1'b0, 1'b0);
        feed(3); feed(4); feed(5);

        // Clear, then four errors to saturate the 2-bit counter
        drive(1'b1, seq_tab[6], 1'b1, 1'b0);
        cur = 6;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0100, 1'b0, 1'b0);
            cur = (cur + 1) % L;
            feed(cur);
        end
        // Fifth error with clear asserted in the same cycle
        drive(1'b1, 4'b0100, 1'b1, 1'b0);
        cur = (cur + 1) % L;
        feed(cur);

        // en gating with toggling code
        for (int i = 0; i < 5; i++) drive(1'b0, int'($urandom_range(0, 15)), 1'b0, 1'b0);

        // Reset while locked with en=1, then hunt restarts
        cur = (cur + 1) % L;
        feed(cur);
        drive(1'b1, seq_tab[(cur + 1) % L], 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) feed(k);
        cur = 3;

        // Random stimulus
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                cur  = (cur + 1) % L;
                code = seq_tab[cur];
            end else if (r < 78) begin
                code = seq_tab[cur];
            end else if (r < 86) begin
                cur  = int'($urandom_range(0, L - 1));
                code = seq_tab[cur];
            end else begin
                code = int'($urandom_range(0, 15));
            end
            e  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 149) == 0);
            drive(e, code, c, rs);
        end
        drive(1'b0, 0, 1'b0, 1'b0);

        @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
